// File: rtl/gather_hazard_unit_if.sv
// gather_hazard_unit_if -- bundles the update stream, the URAM read port and the
// gather-pipe output of gather_hazard_unit.
// slave  : the hazard unit's view (consumes updates and RData, drives the rest).
// master : the surrounding system's view (opposite directions).
interface gather_hazard_unit_if #(
  parameter int PAR_SIZE_W  = 18,
  parameter int URAM_DATA_W = 32
);
  // Update stream (valid/ready)
  logic [31:0]             in_value;
  logic [31:0]             in_dest;
  logic                    in_valid;
  logic                    in_ready;
  // URAM read port
  logic [PAR_SIZE_W-1:0]   RAddr;
  logic                    Ren;
  logic [URAM_DATA_W-1:0]  RData;
  // Gather pipe
  logic [31:0]             update_value;
  logic [31:0]             update_dest;
  logic [URAM_DATA_W-1:0]  dest_attr;
  logic                    input_valid;

  modport slave (
    input  in_value, in_dest, in_valid, RData,
    output in_ready, RAddr, Ren, update_value, update_dest, dest_attr, input_valid
  );

  modport master (
    output in_value, in_dest, in_valid, RData,
    input  in_ready, RAddr, Ren, update_value, update_dest, dest_attr, input_valid
  );
endinterface

// File: rtl/gather_hazard_unit.sv
// gather_hazard_unit -- read-after-write hazard guard in front of a URAM gather pipe.
// Each accepted update issues its URAM read in the same cycle and travels down an
// RD_LAT-deep read stage chain, emerging together with RData. Its address stays in a
// scoreboard for RD_LAT+GATHER_LAT cycles (read plus gather write-back); a new update
// to a tracked address is refused until the entry ages out.
// Optional feature: define HAZARD_STATS_EN to add the saturating stall_cnt output.
module gather_hazard_unit #(
  parameter int PAR_SIZE_W  = 18,
  parameter int URAM_DATA_W = 32,
  parameter int RD_LAT      = 2,
  parameter int GATHER_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  gather_hazard_unit_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int SB_DEPTH = RD_LAT + GATHER_LAT;

  typedef struct packed {
    logic        valid;
    logic [31:0] value;
    logic [31:0] dest;
  } stage_t;

  typedef struct packed {
    logic                  valid;
    logic [PAR_SIZE_W-1:0] addr;
  } sb_entry_t;

  stage_t                stage_q [RD_LAT];
  sb_entry_t             sb_q    [SB_DEPTH];
  logic [PAR_SIZE_W-1:0] raddr_q;
  logic [PAR_SIZE_W-1:0] raddr_d;
  logic [PAR_SIZE_W-1:0] in_addr;
  logic                  hazard;
  logic                  in_ready;
  logic                  accept;

  // Only the partition-local bits address the URAM, so only they can collide.
  assign in_addr = bus.in_dest[PAR_SIZE_W-1:0];

  // Hazard when the incoming address is still owned by any in-flight update.
  always_comb begin
    // NOTE: default first, so no path through the loop leaves hazard unassigned (no latch).
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_q[i].valid && (sb_q[i].addr == in_addr)) hazard = 1'b1;
    end
  end

  // Ready is the only back-pressure; it is withheld for the whole reset cycle.
  assign in_ready = !rst && !hazard;
  assign accept   = bus.in_valid && in_ready;

  // Read address follows an accepted update and otherwise holds its last value.
  always_comb begin
    raddr_d = raddr_q;
    if (accept) raddr_d = in_addr;
  end

  assign bus.in_ready     = in_ready;
  assign bus.Ren          = accept;
  assign bus.RAddr        = rst ? '0 : raddr_d;
  assign bus.input_valid  = !rst && stage_q[RD_LAT-1].valid;
  assign bus.update_value = rst ? '0 : stage_q[RD_LAT-1].value;
  assign bus.update_dest  = rst ? '0 : stage_q[RD_LAT-1].dest;
  assign bus.dest_attr    = rst ? '0 : bus.RData;

  // Advance read stages and scoreboard every cycle; stall cycles inject bubbles.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so each entry samples its predecessor's old value.
    if (rst) begin
      // NOTE: data fields are cleared along with the valids so outputs read 0 after reset.
      for (int i = 0; i < RD_LAT; i++)   stage_q[i] <= '0;
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i]    <= '0;
      raddr_q <= '0;
    end else begin
      stage_q[0].valid <= accept;
      stage_q[0].value <= bus.in_value;
      stage_q[0].dest  <= bus.in_dest;
      for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
      sb_q[0].valid <= accept;
      sb_q[0].addr  <= in_addr;
      for (int i = 1; i < SB_DEPTH; i++) sb_q[i] <= sb_q[i-1];
      raddr_q <= raddr_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Count cycles in which a presented update is refused, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.in_valid && hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gather_hazard_unit.sv
// tb_gather_hazard_unit -- directed vector table for the documented corner cases, then
// randomized traffic checked against a timestamp-based reference model.
// Define HAZARD_STATS_EN to also check the stall counter.
module tb_gather_hazard_unit;

  localparam int PW       = 18;
  localparam int DW       = 32;
  localparam int RD_LAT   = 2;
  localparam int G_LAT    = 1;
  localparam int SB_DEPTH = RD_LAT + G_LAT;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  gather_hazard_unit_if #(.PAR_SIZE_W(PW), .URAM_DATA_W(DW)) bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  gather_hazard_unit #(
    .PAR_SIZE_W (PW),
    .URAM_DATA_W(DW),
    .RD_LAT     (RD_LAT),
    .GATHER_LAT (G_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // URAM contents: a fixed function of the address.
  function automatic logic [31:0] mem_f(input logic [PW-1:0] a);
    return {a[13:0], a} ^ 32'hC3A5_0F1E;
  endfunction

  // URAM behaviour: data for a read appears RD_LAT cycles after Ren.
  logic [PW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= bus.RAddr;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.RData = mem_f(rd_pipe[RD_LAT-1]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          rst;
    logic          vld;
    logic [31:0]   dest;
    logic [31:0]   val;
    logic          exp_ready;
    logic          exp_ren;
    logic [PW-1:0] exp_raddr;
    logic          exp_ivalid;
    logic [31:0]   exp_udest;
    logic [31:0]   exp_uval;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d,
                              input logic [31:0] val, input logic rdy, input logic ren,
                              input logic [PW-1:0] ra, input logic iv,
                              input logic [31:0] ud, input logic [31:0] uv);
    vec_t t;
    t.rst = r; t.vld = v; t.dest = d; t.val = val;
    t.exp_ready = rdy; t.exp_ren = ren; t.exp_raddr = ra;
    t.exp_ivalid = iv; t.exp_udest = ud; t.exp_uval = uv;
    return t;
  endfunction

  task automatic apply_vec(input vec_t v, input int idx);
    rst          = v.rst;
    bus.in_valid = v.vld;
    bus.in_dest  = v.dest;
    bus.in_value = v.val;
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", idx),    32'(bus.in_ready),    32'(v.exp_ready));
    check($sformatf("vec%0d_Ren", idx),         32'(bus.Ren),         32'(v.exp_ren));
    check($sformatf("vec%0d_RAddr", idx),       32'(bus.RAddr),       32'(v.exp_raddr));
    check($sformatf("vec%0d_input_valid", idx), 32'(bus.input_valid), 32'(v.exp_ivalid));
    if (v.exp_ivalid || v.rst) begin
      check($sformatf("vec%0d_update_dest", idx),  bus.update_dest,  v.exp_udest);
      check($sformatf("vec%0d_update_value", idx), bus.update_value, v.exp_uval);
      check($sformatf("vec%0d_dest_attr", idx),    bus.dest_attr,
            v.rst ? 32'd0 : mem_f(v.exp_udest[PW-1:0]));
    end
`ifdef HAZARD_STATS_EN
    if (idx == 7)  check("stall_cnt_after_same_addr", stall_cnt, 32'd3);
    if (idx == 15) check("stall_cnt_after_aliased_addr", stall_cnt, 32'd6);
    if (idx == 27) check("stall_cnt_after_reset", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    logic [PW-1:0] addr;
    logic [31:0] val;
    logic [31:0] dest;
  } acc_t;

  acc_t        hist[$];
  int          cyc;
  logic [PW-1:0] last_raddr;
  logic [31:0] exp_cnt;

  task automatic random_phase(input int n_cycles);
    logic        hold;
    logic        vld;
    logic [31:0] dest;
    logic [31:0] val;
    logic        r;
    logic        hz;
    logic        rdy;
    logic        ren;
    logic [PW-1:0] ra;
    logic        ov;
    logic [31:0] ouv;
    logic [31:0] oud;
    hold = 1'b0; vld = 1'b0; dest = '0; val = '0;
    for (int k = 0; k < n_cycles; k++) begin
      r = (k < 2) || ($urandom_range(0, 149) == 0);
      if (!hold) begin
        vld  = ($urandom_range(0, 3) != 0);
        dest = {($urandom_range(0, 3) == 0) ? 14'($urandom_range(1, 3)) : 14'd0,
                18'($urandom_range(0, 5))};
        val  = $urandom;
      end
      rst = r; bus.in_valid = vld; bus.in_dest = dest; bus.in_value = val;

      // An address is busy for SB_DEPTH cycles after the cycle it was accepted in.
      while (hist.size() > 0 && (cyc - hist[0].cyc) > SB_DEPTH) void'(hist.pop_front());
      hz = 1'b0; ov = 1'b0; ouv = '0; oud = '0;
      foreach (hist[j]) begin
        if (hist[j].addr == dest[PW-1:0] && (cyc - hist[j].cyc) <= SB_DEPTH) hz = 1'b1;
        if ((cyc - hist[j].cyc) == RD_LAT) begin
          ov = 1'b1; ouv = hist[j].val; oud = hist[j].dest;
        end
      end
      rdy = !r && !hz;
      ren = vld && rdy;
      ra  = r ? '0 : (ren ? dest[PW-1:0] : last_raddr);
      if (r) ov = 1'b0;

      @(negedge clk);
      check("rnd_in_ready",    32'(bus.in_ready),    32'(rdy));
      check("rnd_Ren",         32'(bus.Ren),         32'(ren));
      check("rnd_RAddr",       32'(bus.RAddr),       32'(ra));
      check("rnd_input_valid", 32'(bus.input_valid), 32'(ov));
      if (ov) begin
        check("rnd_update_value", bus.update_value, ouv);
        check("rnd_update_dest",  bus.update_dest,  oud);
        check("rnd_dest_attr",    bus.dest_attr,    mem_f(oud[PW-1:0]));
      end
`ifdef HAZARD_STATS_EN
      if (!r) check("rnd_stall_cnt", stall_cnt, exp_cnt);
`endif

      if (r) begin
        hist.delete();
        last_raddr = '0;
        exp_cnt    = '0;
      end else begin
        if (ren) hist.push_back('{cyc: cyc, addr: dest[PW-1:0], val: val, dest: dest});
        last_raddr = ra;
        if (vld && hz && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      end
      hold = vld && !ren;
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_dest  = '0;
    bus.in_value = '0;
    cyc = 0;
    last_raddr = '0;
    exp_cnt = '0;

    //               rst vld dest        val       rdy ren raddr iv udest      uval
    vecs.push_back(mk(1, 0, 0,          0,        0,  0,  0,    0, 0,         0));
    vecs.push_back(mk(1, 1, 5,          'h11,     0,  0,  0,    0, 0,         0));
    // same address twice: stall cycles 1-3, accept 4, outputs at 2 and 6
    vecs.push_back(mk(0, 1, 5,          'hA0,     1,  1,  5,    0, 0,         0));
    vecs.push_back(mk(0, 1, 5,          'hA1,     0,  0,  5,    0, 0,         0));
    vecs.push_back(mk(0, 1, 5,          'hA1,     0,  0,  5,    1, 5,         'hA0));
    vecs.push_back(mk(0, 1, 5,          'hA1,     0,  0,  5,    0, 0,         0));
    vecs.push_back(mk(0, 1, 5,          'hA1,     1,  1,  5,    0, 0,         0));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  5,    0, 0,         0));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  5,    1, 5,         'hA1));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  5,    0, 0,         0));
    // addresses equal only in the low PAR_SIZE_W bits
    vecs.push_back(mk(0, 1, 'h40005,    'hB0,     1,  1,  5,    0, 0,         0));
    vecs.push_back(mk(0, 1, 5,          'hB1,     0,  0,  5,    0, 0,         0));
    vecs.push_back(mk(0, 1, 5,          'hB1,     0,  0,  5,    1, 'h40005,   'hB0));
    vecs.push_back(mk(0, 1, 5,          'hB1,     0,  0,  5,    0, 0,         0));
    vecs.push_back(mk(0, 1, 5,          'hB1,     1,  1,  5,    0, 0,         0));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  5,    0, 0,         0));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  5,    1, 5,         'hB1));
    // distinct addresses back to back
    vecs.push_back(mk(0, 1, 1,          'hC1,     1,  1,  1,    0, 0,         0));
    vecs.push_back(mk(0, 1, 2,          'hC2,     1,  1,  2,    0, 0,         0));
    vecs.push_back(mk(0, 1, 3,          'hC3,     1,  1,  3,    1, 1,         'hC1));
    vecs.push_back(mk(0, 1, 4,          'hC4,     1,  1,  4,    1, 2,         'hC2));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  4,    1, 3,         'hC3));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  4,    1, 4,         'hC4));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  4,    0, 0,         0));
    // reset with two updates in flight, then dest 5 again without a stall
    vecs.push_back(mk(0, 1, 5,          'hD5,     1,  1,  5,    0, 0,         0));
    vecs.push_back(mk(0, 1, 6,          'hD6,     1,  1,  6,    0, 0,         0));
    vecs.push_back(mk(1, 0, 0,          0,        0,  0,  0,    0, 0,         0));
    vecs.push_back(mk(0, 1, 5,          'hE5,     1,  1,  5,    0, 0,         0));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  5,    0, 0,         0));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  5,    1, 5,         'hE5));
    vecs.push_back(mk(0, 0, 0,          0,        1,  0,  5,    0, 0,         0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

`ifdef HAZARD_STATS_EN
    // Saturation: preload near the top, then keep hammering one address.
    dut.stall_cnt_q = 32'hFFFF_FFFD;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_dest  = 32'd9;
    bus.in_value = 32'h99;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stall_cnt_saturated", stall_cnt, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
`endif

    random_phase(800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
